// File: rtl/ro_measure_sequencer.sv
// Ring-oscillator measurement sequencer: settle / gate window / resync per sample,
// accumulates 2^LOG2_NSAMP samples and strobes the sum for one cycle.
module ro_measure_sequencer #(
    parameter int CNT_W      = 16,
    parameter int LOG2_NSAMP = 2,
    parameter int SETTLE_CYC = 2,
    parameter int WINDOW_CYC = 1024,
    parameter int SYNC_CYC   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          cont_mode,
    input  logic                          abort,
    input  logic [CNT_W-1:0]              ro_count,
    output logic                          ro_en,
    output logic                          cnt_clear,
    output logic                          cnt_gate,
    output logic                          busy,
    output logic [CNT_W+LOG2_NSAMP-1:0]   sum,
    output logic                          sum_ready
);
    localparam int SW    = CNT_W + LOG2_NSAMP;
    localparam int NSAMP = 1 << LOG2_NSAMP;
    localparam int MAX_A = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
    localparam int MAXC  = (MAX_A > SYNC_CYC) ? MAX_A : SYNC_CYC;
    localparam int TW    = $clog2(MAXC + 1);
    localparam int IW    = (LOG2_NSAMP > 0) ? LOG2_NSAMP : 1;

    typedef enum logic [2:0] {IDLE, SETTLE, COUNT, CAPTURE, DONE} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [SW-1:0] sum_q, sum_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE:    if (start && !abort) state_d = SETTLE;
            SETTLE:  if (timer_q == TW'(SETTLE_CYC - 1)) state_d = COUNT;
            COUNT:   if (timer_q == TW'(WINDOW_CYC - 1)) state_d = CAPTURE;
            CAPTURE: begin
                if (timer_q == TW'(SYNC_CYC - 1)) begin
                    if (idx_q == IW'(NSAMP - 1)) begin
                        sum_d   = acc_q + SW'(ro_count);
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        acc_d   = acc_q + SW'(ro_count);
                        idx_d   = idx_q + 1'b1;
                        state_d = SETTLE;
                    end
                end
            end
            DONE:    state_d = cont_mode ? SETTLE : IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a capture that would publish a sum.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            acc_d   = '0;
            idx_d   = '0;
            sum_d   = sum_q;
        end
        timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
    end

    always_comb begin
        ro_en     = 1'b0;
        cnt_clear = 1'b0;
        cnt_gate  = 1'b0;
        sum_ready = 1'b0;
        case (state_q)
            SETTLE:  begin ro_en = 1'b1; cnt_clear = 1'b1; end
            COUNT:   begin ro_en = 1'b1; cnt_gate  = 1'b1; end
            DONE:    sum_ready = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign sum  = sum_q;

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Bench for ro_measure_sequencer: cycle-arithmetic reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ro_measure_sequencer;
    localparam int CNT_W = 16, LOG2 = 2, S = 2, W = 8, Y = 2;
    localparam int SW = CNT_W + LOG2, N = 1 << LOG2, P = S + W + Y;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, cont_mode = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] ro_count = '0;
    logic ro_en, cnt_clear, cnt_gate, busy, sum_ready;
    logic [SW-1:0] sum;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, t0 = 0;

    ro_measure_sequencer #(.CNT_W(CNT_W), .LOG2_NSAMP(LOG2), .SETTLE_CYC(S),
                           .WINDOW_CYC(W), .SYNC_CYC(Y)) dut (
        .clk(clk), .reset(reset), .start(start), .cont_mode(cont_mode), .abort(abort),
        .ro_count(ro_count), .ro_en(ro_en), .cnt_clear(cnt_clear), .cnt_gate(cnt_gate),
        .busy(busy), .sum(sum), .sum_ready(sum_ready));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: position t within a conversion (1-based) decides the phase.
    initial begin : model
        bit m_act;
        int m_t, o;
        logic [SW-1:0] m_acc, m_sum;
        logic e_en, e_clr, e_gate, e_rdy;
        m_act = 0; m_t = 0; m_acc = '0; m_sum = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_act = 0; m_acc = '0; m_sum = '0;
                chk("rst_outputs", {ro_en, cnt_clear, cnt_gate, busy, sum_ready}, 0);
                chk("rst_sum", sum, 0);
            end else begin
                e_en = 0; e_clr = 0; e_gate = 0; e_rdy = 0;
                if (m_act) begin
                    if (m_t > N * P) e_rdy = 1;
                    else begin
                        o = (m_t - 1) % P;
                        if (o < S) begin e_en = 1; e_clr = 1; end
                        else if (o < S + W) begin e_en = 1; e_gate = 1; end
                    end
                end
                chk("model_ro_en", ro_en, e_en);
                chk("model_cnt_clear", cnt_clear, e_clr);
                chk("model_cnt_gate", cnt_gate, e_gate);
                chk("model_sum_ready", sum_ready, e_rdy);
                chk("model_busy", busy, m_act);
                chk("model_sum", sum, m_sum);
                if (m_act) begin
                    if (abort) begin m_act = 0; m_acc = '0; end
                    else if (m_t > N * P) begin
                        if (cont_mode) m_t = 1; else m_act = 0;
                    end else begin
                        if ((m_t - 1) % P == P - 1) begin
                            if (m_t == N * P) begin m_sum = m_acc + SW'(ro_count); m_acc = '0; end
                            else m_acc = m_acc + SW'(ro_count);
                        end
                        m_t++;
                    end
                end else if (start && !abort) begin
                    m_act = 1; m_t = 1;
                end
            end
        end
    end

    // Start pulse sampled at edge 0; cycle c then begins at edge c-1.
    task automatic start_conv();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #1 t0 = cyc; #1 start = 1'b0;
    endtask

    // Returns 3 time units into cycle c of the current conversion.
    task automatic at_cycle(input int c);
        int g = 0;
        while (cyc < t0 + c - 1 && g < 1000) begin @(posedge clk); #1; g++; end
        if (g >= 1000) chk("at_cycle_timeout", g, 0);
        #2;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 500) begin @(posedge clk); #3; g++; end
        chk("wait_idle", busy, 0);
    endtask

    logic [SW-1:0] prev_sum;

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("reset_outputs", {ro_en, cnt_clear, cnt_gate, busy, sum_ready}, 0);
        chk("reset_sum", sum, 0);
        @(posedge clk); #3 reset = 1'b0;
        repeat (2) @(posedge clk);

        // Single shot, constant count
        ro_count = 16'd100;
        start_conv();
        at_cycle(2);  chk("ss_clear_c2", cnt_clear, 1); chk("ss_gate_c2", cnt_gate, 0);
        at_cycle(3);  chk("ss_gate_c3", cnt_gate, 1);
        at_cycle(10); chk("ss_gate_c10", cnt_gate, 1);
        at_cycle(11); chk("ss_gate_c11", cnt_gate, 0); chk("ss_roen_c11", ro_en, 0);
        at_cycle(15); chk("ss_gate_c15", cnt_gate, 1);
        at_cycle(48); chk("ss_rdy_c48", sum_ready, 0);
        at_cycle(49); chk("ss_rdy_c49", sum_ready, 1); chk("ss_sum", sum, 400);
        at_cycle(50); chk("ss_busy_c50", busy, 0); chk("ss_sum_hold", sum, 400);

        // Varying samples, no wrap in the wider sum
        ro_count = 16'd10;
        start_conv();
        at_cycle(13); ro_count = 16'd20;
        at_cycle(25); ro_count = 16'd30;
        at_cycle(37); ro_count = 16'hFFFF;
        at_cycle(49); chk("vary_rdy", sum_ready, 1); chk("vary_sum", sum, 65595);
        wait_idle();

        // Start while busy is ignored
        ro_count = 16'd7;
        start_conv();
        at_cycle(5);  start = 1'b1;
        at_cycle(6);  start = 1'b0;
        at_cycle(30); start = 1'b1;
        at_cycle(31); start = 1'b0;
        at_cycle(49); chk("swb_rdy", sum_ready, 1); chk("swb_sum", sum, 28);
        at_cycle(50); chk("swb_busy", busy, 0);

        // Abort mid-COUNT of the second sample
        prev_sum = sum;
        ro_count = 16'd3;
        start_conv();
        at_cycle(20); chk("ab_gate_c20", cnt_gate, 1); abort = 1'b1;
        at_cycle(21); abort = 1'b0;
        chk("ab_busy", busy, 0); chk("ab_roen", ro_en, 0); chk("ab_sum", sum, prev_sum);
        ro_count = 16'd9;
        start_conv();
        at_cycle(49); chk("ab_restart_sum", sum, 36); chk("ab_restart_rdy", sum_ready, 1);
        wait_idle();

        // Abort together with start in IDLE stays idle
        @(posedge clk); #2 start = 1'b1; abort = 1'b1;
        @(posedge clk); #3 chk("idle_abort_busy", busy, 0); start = 1'b0; abort = 1'b0;

        // Continuous: DONE at 49, next SETTLE at 50, next DONE at 98
        cont_mode = 1'b1;
        ro_count = 16'd5;
        start_conv();
        at_cycle(49); chk("cont_rdy1", sum_ready, 1); chk("cont_sum1", sum, 20);
        at_cycle(50); chk("cont_busy", busy, 1); chk("cont_clear", cnt_clear, 1);
        at_cycle(98); chk("cont_rdy2", sum_ready, 1); chk("cont_sum2", sum, 20);
        cont_mode = 1'b0;
        at_cycle(99); chk("cont_stop", busy, 0);

        // Async reset mid-COUNT, between edges
        start_conv();
        at_cycle(5);
        chk("ar_pre_gate", cnt_gate, 1);
        reset = 1'b1;
        #1;
        chk("ar_roen", ro_en, 0); chk("ar_gate", cnt_gate, 0);
        chk("ar_busy", busy, 0); chk("ar_sum", sum, 0);
        @(posedge clk); @(posedge clk); #3 reset = 1'b0;
        repeat (4) @(posedge clk);
        #3 chk("ar_idle_wait", busy, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
